counter_inc_dec_mc: RTL and testbench

//  Multi-channel, parametrised successor to the 8-bit inc/dec counter.
//  NUM_CH independent up/down counters share one clock and reset.

---
 rtl/counter_inc_dec_mc_pkg.sv | 63 ++++++
 rtl/counter_inc_dec_mc_ch.sv | 90 +++++++++
 rtl/counter_inc_dec_mc_sva.sv | 41 ++++
 rtl/counter_inc_dec_mc.sv | 54 +++++
 tb/tb_counter_inc_dec_mc.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_inc_dec_mc_pkg.sv
// Shared types, limits and the next-count function used by the counter
// channels and the bound assertion block.
package counter_pkg;

  localparam int W_MAX = 32;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  typedef logic [W_MAX-1:0] cnt_w_t;
  typedef logic [W_MAX:0]   cnt_x_t;

  typedef struct packed {
    cnt_w_t cnt;
    logic   ovf;
    logic   udf;
  } cnt_res_t;

  // Step arithmetic in W+1 bits (here W_MAX+1 so one body serves every
  // width); the carry out of bit w-1 marks a crossing.
  function automatic cnt_res_t next_cnt(
    input cnt_w_t    cnt,
    input logic      inc,
    input logic      dec,
    input int        w,
    input cnt_w_t    step,
    input cnt_mode_t mode
  );
    cnt_x_t   top;
    cnt_x_t   c;
    cnt_x_t   s;
    cnt_x_t   d;
    cnt_res_t r;
    top   = (cnt_x_t'(1) << w) - cnt_x_t'(1);
    c     = cnt_x_t'(cnt);
    s     = c + cnt_x_t'(step);
    d     = c - cnt_x_t'(step);
    r.cnt = cnt;
    r.ovf = 1'b0;
    r.udf = 1'b0;
    if (inc && !dec) begin
      if (s > top) begin
        r.ovf = 1'b1;
        r.cnt = (mode == CNT_SAT) ?
                cnt_w_t'(top) : cnt_w_t'(s & top);
      end else begin
        r.cnt = cnt_w_t'(s);
      end
    end else if (dec && !inc) begin
      if (c < cnt_x_t'(step)) begin
        r.udf = 1'b1;
        r.cnt = (mode == CNT_SAT) ?
                '0 : cnt_w_t'(d & top);
      end else begin
        r.cnt = cnt_w_t'(d);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_inc_dec_mc_ch.sv
// One up/down counter channel: clr > load > step, wrap or saturate.
// Ports: clk, rst_n, clr, load, load_val, inc, dec, stat_clr in;
//        cnt, zero, full, ovf, udf, ovf_stk, udf_stk out.
module counter_ch
  import counter_pkg::*;
#(
  parameter int W        = 8,
  parameter int STEP     = 1,
  parameter int RST_VAL  = 0,
  parameter int SAT_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic         stat_clr,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full,
  output logic         ovf,
  output logic         udf,
  output logic         ovf_stk,
  output logic         udf_stk
);

  localparam logic [W-1:0] RST_CNT = W'(RST_VAL);
  localparam cnt_w_t STEP_W = cnt_w_t'(STEP);
  localparam cnt_mode_t MODE =
    (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         ovf_stk_q, ovf_stk_d;
  logic         udf_stk_q, udf_stk_d;
  logic         load_only;
  cnt_res_t     res;
  logic         unused_res;

  assign load_only  = load & ~clr;
  assign unused_res = ^res.cnt;

  always_comb begin
    res   = next_cnt(cnt_w_t'(cnt_q), inc, dec,
                     W, STEP_W, MODE);
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    unique case (1'b1)
      clr:       cnt_d = RST_CNT;
      load_only: cnt_d = load_val;
      default: begin
        cnt_d = res.cnt[W-1:0];
        ovf_d = res.ovf;
        udf_d = res.udf;
      end
    endcase
    // stat_clr beats a same-cycle event
    ovf_stk_d = (ovf_stk_q | ovf_d) & ~stat_clr;
    udf_stk_d = (udf_stk_q | udf_d) & ~stat_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RST_CNT;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_stk_q <= 1'b0;
      udf_stk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ovf_stk_q <= ovf_stk_d;
      udf_stk_q <= udf_stk_d;
    end
  end

  assign cnt     = cnt_q;
  assign zero    = (cnt_q == '0);
  assign full    = &cnt_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign ovf_stk = ovf_stk_q;
  assign udf_stk = udf_stk_q;

endmodule

// File: rtl/counter_inc_dec_mc_sva.sv
// Property checks bound into every counter_ch instance.
// Ports: observe-only copies of the channel's control and outputs.
module counter_ch_sva #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clr,
  input logic         load,
  input logic         inc,
  input logic         dec,
  input logic         ovf,
  input logic         udf,
  input logic [W-1:0] cnt
);

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (!clr && !load && (inc == dec)) |=> $stable(cnt));

  a_ovf_src: assert property (
    @(posedge clk) disable iff (!rst_n)
    ovf |-> $past(inc & ~dec & ~clr & ~load));

  a_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(ovf && udf));

endmodule

bind counter_ch counter_ch_sva #(.W(W)) u_sva (
  .clk   (clk),
  .rst_n (rst_n),
  .clr   (clr),
  .load  (load),
  .inc   (inc),
  .dec   (dec),
  .ovf   (ovf),
  .udf   (udf),
  .cnt   (cnt)
);

// File: rtl/counter_inc_dec_mc.sv
// NUM_CH independent up/down counters with flags, sharing clk/rst_n.
// Ports: per-channel bit vectors; load_val/cnt sliced as [i*W +: W].
module counter_inc_dec_mc
  import counter_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int W        = 8,
  parameter int STEP     = 1,
  parameter int RST_VAL  = 0,
  parameter int SAT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   clr,
  input  logic [NUM_CH-1:0]   load,
  input  logic [NUM_CH*W-1:0] load_val,
  input  logic [NUM_CH-1:0]   inc,
  input  logic [NUM_CH-1:0]   dec,
  input  logic [NUM_CH-1:0]   stat_clr,
  output logic [NUM_CH*W-1:0] cnt,
  output logic [NUM_CH-1:0]   zero,
  output logic [NUM_CH-1:0]   full,
  output logic [NUM_CH-1:0]   ovf,
  output logic [NUM_CH-1:0]   udf,
  output logic [NUM_CH-1:0]   ovf_stk,
  output logic [NUM_CH-1:0]   udf_stk
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_ch #(
      .W        (W),
      .STEP     (STEP),
      .RST_VAL  (RST_VAL),
      .SAT_MODE (SAT_MODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr[i]),
      .load     (load[i]),
      .load_val (load_val[i*W +: W]),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .stat_clr (stat_clr[i]),
      .cnt      (cnt[i*W +: W]),
      .zero     (zero[i]),
      .full     (full[i]),
      .ovf      (ovf[i]),
      .udf      (udf[i]),
      .ovf_stk  (ovf_stk[i]),
      .udf_stk  (udf_stk[i])
    );
  end

endmodule

// File: tb/tb_counter_inc_dec_mc.sv
// Bench: four counter configurations on shared stimulus, checked
// against an integer reference model every cycle.
module tb_counter_inc_dec_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  clr, load, inc, dec, stat_clr;
  logic [31:0] lv8;
  logic [15:0] lv4;

  logic [31:0] cnt8 [2];
  logic [15:0] cnt4 [2];
  logic [3:0]  zero_o [4];
  logic [3:0]  full_o [4];
  logic [3:0]  ovf_o [4];
  logic [3:0]  udf_o [4];
  logic [3:0]  os_o [4];
  logic [3:0]  us_o [4];

  // d0: W8 sat, d1: W8 wrap, d2: W4 step3 wrap, d3: W4 step3 sat
  int pw [4]   = '{8, 8, 4, 4};
  int ps [4]   = '{1, 1, 3, 3};
  int psat [4] = '{1, 0, 0, 1};

  int mc [4][4];
  bit mo [4][4];
  bit mu [4][4];
  bit mos [4][4];
  bit mus [4][4];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_inc_dec_mc #(.W(8), .STEP(1), .SAT_MODE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(lv8), .inc(inc), .dec(dec), .stat_clr(stat_clr),
    .cnt(cnt8[0]), .zero(zero_o[0]), .full(full_o[0]),
    .ovf(ovf_o[0]), .udf(udf_o[0]),
    .ovf_stk(os_o[0]), .udf_stk(us_o[0]));

  counter_inc_dec_mc #(.W(8), .STEP(1), .SAT_MODE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(lv8), .inc(inc), .dec(dec), .stat_clr(stat_clr),
    .cnt(cnt8[1]), .zero(zero_o[1]), .full(full_o[1]),
    .ovf(ovf_o[1]), .udf(udf_o[1]),
    .ovf_stk(os_o[1]), .udf_stk(us_o[1]));

  counter_inc_dec_mc #(.W(4), .STEP(3), .SAT_MODE(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(lv4), .inc(inc), .dec(dec), .stat_clr(stat_clr),
    .cnt(cnt4[0]), .zero(zero_o[2]), .full(full_o[2]),
    .ovf(ovf_o[2]), .udf(udf_o[2]),
    .ovf_stk(os_o[2]), .udf_stk(us_o[2]));

  counter_inc_dec_mc #(.W(4), .STEP(3), .SAT_MODE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
    .load_val(lv4), .inc(inc), .dec(dec), .stat_clr(stat_clr),
    .cnt(cnt4[1]), .zero(zero_o[3]), .full(full_o[3]),
    .ovf(ovf_o[3]), .udf(udf_o[3]),
    .ovf_stk(os_o[3]), .udf_stk(us_o[3]));

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        mc[d][c] = 0; mo[d][c] = 0; mu[d][c] = 0;
        mos[d][c] = 0; mus[d][c] = 0;
      end
  endtask

  task automatic model_step();
    int mx, v, lv, st;
    bit no, nu;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) begin
        mx = (1 << pw[d]) - 1;
        st = ps[d];
        lv = (pw[d] == 8) ? int'(lv8[c*8 +: 8])
                          : int'(lv4[c*4 +: 4]);
        v  = mc[d][c];
        no = 0;
        nu = 0;
        if (clr[c]) v = 0;
        else if (load[c]) v = lv;
        else if (inc[c] && !dec[c]) begin
          if (v + st > mx) begin
            no = 1;
            v  = psat[d] ? mx : v + st - (mx + 1);
          end else v = v + st;
        end else if (dec[c] && !inc[c]) begin
          if (v < st) begin
            nu = 1;
            v  = psat[d] ? 0 : v - st + (mx + 1);
          end else v = v - st;
        end
        mc[d][c]  = v;
        mo[d][c]  = no;
        mu[d][c]  = nu;
        mos[d][c] = (mos[d][c] | no) & ~stat_clr[c];
        mus[d][c] = (mus[d][c] | nu) & ~stat_clr[c];
      end
  endtask

  task automatic compare_all();
    logic [31:0] ec, ac;
    logic [3:0] ez, ef, eo, eu, eos, eus;
    int mx;
    for (int d = 0; d < 4; d++) begin
      mx = (1 << pw[d]) - 1;
      ec = '0;
      for (int c = 0; c < 4; c++) begin
        ec = ec | (32'(mc[d][c]) << (c * pw[d]));
        ez[c]  = (mc[d][c] == 0);
        ef[c]  = (mc[d][c] == mx);
        eo[c]  = mo[d][c];
        eu[c]  = mu[d][c];
        eos[c] = mos[d][c];
        eus[c] = mus[d][c];
      end
      if (d < 2) ac = cnt8[d];
      else if (d == 2) ac = 32'(cnt4[0]);
      else ac = 32'(cnt4[1]);
      check($sformatf("d%0d_cnt", d), ac, ec);
      check($sformatf("d%0d_zero", d), 32'(zero_o[d]), 32'(ez));
      check($sformatf("d%0d_full", d), 32'(full_o[d]), 32'(ef));
      check($sformatf("d%0d_ovf", d), 32'(ovf_o[d]), 32'(eo));
      check($sformatf("d%0d_udf", d), 32'(udf_o[d]), 32'(eu));
      check($sformatf("d%0d_ostk", d), 32'(os_o[d]), 32'(eos));
      check($sformatf("d%0d_ustk", d), 32'(us_o[d]), 32'(eus));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    clr = '0; load = '0; inc = '0; dec = '0;
    stat_clr = '0; lv8 = '0; lv4 = '0;
  endtask

  task automatic rand_in();
    for (int c = 0; c < 4; c++) begin
      clr[c]      = ($urandom_range(0, 31) == 0);
      load[c]     = ($urandom_range(0, 9) == 0);
      inc[c]      = ($urandom_range(0, 1) == 1);
      dec[c]      = ($urandom_range(0, 2) == 0);
      stat_clr[c] = ($urandom_range(0, 15) == 0);
    end
    lv8 = $urandom;
    lv4 = 16'($urandom);
  endtask

  initial begin
    idle();
    model_reset();
    // 1. reset
    repeat (7) cyc();
    check("rst_cnt", cnt8[0], 32'h0);
    check("rst_zero", 32'(zero_o[0]), 32'hf);
    check("rst_ostk", 32'(os_o[1]), 32'h0);
    rst_n = 1'b1;
    repeat (3) cyc();
    check("rel_cnt", cnt8[1], 32'h0);

    // 2. wrap on d1 ch0
    idle(); load = 4'b0001; lv8[7:0] = 8'hfe; cyc();
    check("wr_load", 32'(cnt8[1][7:0]), 32'hfe);
    idle(); inc = 4'b0001; cyc();
    check("wr_ff", 32'(cnt8[1][7:0]), 32'hff);
    check("wr_ff_ovf", 32'(ovf_o[1][0]), 32'h0);
    cyc();
    check("wr_00", 32'(cnt8[1][7:0]), 32'h00);
    check("wr_00_ovf", 32'(ovf_o[1][0]), 32'h1);
    cyc();
    check("wr_01", 32'(cnt8[1][7:0]), 32'h01);
    check("wr_01_ovf", 32'(ovf_o[1][0]), 32'h0);
    check("wr_stk", 32'(os_o[1][0]), 32'h1);
    idle(); cyc();
    check("wr_stk_hold", 32'(os_o[1][0]), 32'h1);
    stat_clr = 4'b0001; cyc();
    check("wr_stk_clr", 32'(os_o[1][0]), 32'h0);
    idle(); load = 4'b0001; cyc();
    idle(); dec = 4'b0001; cyc();
    check("wr_dec_ff", 32'(cnt8[1][7:0]), 32'hff);
    check("wr_udf", 32'(udf_o[1][0]), 32'h1);

    // 3. saturate on d0 ch1
    idle(); load = 4'b0010; lv8[15:8] = 8'hff; cyc();
    idle(); inc = 4'b0010; cyc();
    check("sat_ff1", 32'(cnt8[0][15:8]), 32'hff);
    check("sat_ovf1", 32'(ovf_o[0][1]), 32'h1);
    cyc();
    check("sat_ff2", 32'(cnt8[0][15:8]), 32'hff);
    check("sat_ovf2", 32'(ovf_o[0][1]), 32'h1);
    idle(); load = 4'b0010; cyc();
    idle(); dec = 4'b0010; cyc();
    check("sat_00", 32'(cnt8[0][15:8]), 32'h00);
    check("sat_udf", 32'(udf_o[0][1]), 32'h1);

    // 4. priority on d0 ch2
    idle(); load = 4'b0100; lv8[23:16] = 8'h33; cyc();
    idle(); clr = 4'b0100; load = 4'b0100;
    lv8[23:16] = 8'h55; inc = 4'b0100; cyc();
    check("pri_clr", 32'(cnt8[0][23:16]), 32'h00);
    idle(); load = 4'b0100; lv8[23:16] = 8'h55;
    inc = 4'b0100; cyc();
    check("pri_load", 32'(cnt8[0][23:16]), 32'h55);
    idle(); inc = 4'b0100; dec = 4'b0100; cyc();
    check("pri_hold", 32'(cnt8[0][23:16]), 32'h55);
    check("pri_noflag", 32'({ovf_o[0][2], udf_o[0][2]}), 32'h0);

    // 5. step 3, width 4 on d2 (wrap) and d3 (sat), ch0
    idle(); load = 4'b0001; lv4[3:0] = 4'd14; cyc();
    idle(); inc = 4'b0001; cyc();
    check("s3w_inc", 32'(cnt4[0][3:0]), 32'd1);
    check("s3w_ovf", 32'(ovf_o[2][0]), 32'h1);
    check("s3s_inc", 32'(cnt4[1][3:0]), 32'd15);
    check("s3s_ovf", 32'(ovf_o[3][0]), 32'h1);
    idle(); dec = 4'b0001; cyc();
    check("s3w_dec", 32'(cnt4[0][3:0]), 32'd14);
    check("s3w_udf", 32'(udf_o[2][0]), 32'h1);

    // stat_clr colliding with an event, d0 ch3
    idle(); load = 4'b1000; lv8[31:24] = 8'hff; cyc();
    idle(); inc = 4'b1000; stat_clr = 4'b1000; cyc();
    check("col_ovf", 32'(ovf_o[0][3]), 32'h1);
    check("col_stk", 32'(os_o[0][3]), 32'h0);
    stat_clr = '0; cyc();
    check("col_stk2", 32'(os_o[0][3]), 32'h1);

    // 6. random run with an async reset in the middle
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("mid_rst_cnt", cnt8[1], 32'h0);
        check("mid_rst_ovf", 32'(ovf_o[0]), 32'h0);
        idle();
        repeat (2) cyc();
        rst_n = 1'b1;
      end
      rand_in();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got 1 want 0");
    $fatal(1);
  end

endmodule
